loa_error_eval: RTL

- Self-contained sequential characterisation engine for lower-part-OR approximate adders.
- On `start` it sweeps every operand pair of a W-bit adder with P approximated LSBs. For each pair it compares the approximate sum against the exact sum and accumulates error metrics.
- Sits beside the approximate-adder library as its on-chip evaluator. It consumes adder results rather than producing them, and feeds a status/register interface.

---
 rtl/loa_eval_pkg.sv | 31 +++
 rtl/loa_err_calc.sv | 47 ++++
 rtl/loa_error_eval.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/loa_eval_pkg.sv
// Shared types and width helpers for the lower-part-OR adder error evaluator.
//   state_t : sweep controller states
//   cnt_w   : width of the error-count accumulator   (2W+1)
//   sae_w   : width of the sum-of-absolute-errors    (2W+P+1)
//   sum_w   : width of the signed error sum          (2W+P+2)
//   max_w   : width of the maximum absolute error    (P+1)
package loa_eval_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int cnt_w(input int w);
      return 2 * w + 1;
   endfunction

   function automatic int sae_w(input int w, input int p);
      return 2 * w + p + 1;
   endfunction

   function automatic int sum_w(input int w, input int p);
      return 2 * w + p + 2;
   endfunction

   function automatic int max_w(input int p);
      return p + 1;
   endfunction

endpackage

// File: rtl/loa_err_calc.sv
// Combinational error model for a W-bit lower-part-OR adder with P
// approximated LSBs. Computes both the exact and the approximate sum and
// returns their difference.
//   a, b  : operands (W bits)
//   e     : exact - approx, two's complement, W+2 bits
//   e_abs : |e|, P+1 bits (|e| < 2^P always holds)
module loa_err_calc
   import loa_eval_pkg::*;
#(
   parameter int W = 6,
   parameter int P = 2
) (
   input  logic [W-1:0]        a,
   input  logic [W-1:0]        b,
   output logic signed [W+1:0] e,
   output logic [P:0]          e_abs
);

   localparam logic [W-1:0] LO_MASK = W'((64'd1 << P) - 64'd1);

   logic         carry;
   logic [W:0]   exact;
   logic [W:0]   hi_sum;
   logic [W:0]   approx;

   // Carry into the exact upper part is the AND of the top approximated bit pair.
   generate
      if (P > 0) begin : g_carry
         assign carry = a[P-1] & b[P-1];
      end else begin : g_no_carry
         assign carry = 1'b0;
      end
   endgenerate

   assign exact  = {1'b0, a} + {1'b0, b};

   // Masked operands leave the low P bits of hi_sum at zero, so the OR part
   // can be merged in without interfering.
   assign hi_sum = {1'b0, a & ~LO_MASK} + {1'b0, b & ~LO_MASK} + ((W + 1)'(carry) << P);
   assign approx = hi_sum | {1'b0, (a | b) & LO_MASK};

   assign e = $signed({1'b0, exact}) - $signed({1'b0, approx});

   // |e| < 2^P, so negating only the low P+1 bits is exact.
   assign e_abs = e[W+1] ? (~e[P:0] + (P + 1)'(1)) : e[P:0];

endmodule

// File: rtl/loa_error_eval.sv
// Sequential characterisation engine for lower-part-OR approximate adders.
// On start it sweeps every operand pair {a,b} (b fastest), registers the
// per-pair error, and accumulates error metrics one cycle later.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a sweep (sampled only in IDLE)
//   busy     : high during SWEEP and DRAIN (N+1 cycles)
//   done     : one-cycle pulse in the first IDLE cycle after a sweep
//   err_cnt  : number of pairs with nonzero error
//   sae      : sum of absolute errors
//   err_sum  : signed sum of (exact - approx)
//   max_abs  : largest absolute error seen
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last results
// SWEEP | one operand pair issued per cycle into the error register
// DRAIN | last registered error accumulated, then back to IDLE
module loa_error_eval
   import loa_eval_pkg::*;
#(
   parameter int W = 6,
   parameter int P = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [cnt_w(W)-1:0]      err_cnt,
   output logic [sae_w(W, P)-1:0]   sae,
   output logic [sum_w(W, P)-1:0]   err_sum,
   output logic [max_w(P)-1:0]      max_abs
);

   localparam int CNT_W = cnt_w(W);
   localparam int SAE_W = sae_w(W, P);
   localparam int SUM_W = sum_w(W, P);
   localparam logic [2*W-1:0] LAST_PAIR = '1;

   state_t state, state_nxt;
   logic   clear;
   logic   issue;

   logic [2*W-1:0]        cnt;
   logic signed [W+1:0]   e_now;
   logic [P:0]            abs_now;
   logic signed [W+1:0]   e_q;
   logic [P:0]            abs_q;
   logic                  valid_q;

   loa_err_calc #(
      .W (W),
      .P (P)
   ) u_calc (
      .a     (cnt[2*W-1:W]),
      .b     (cnt[W-1:0]),
      .e     (e_now),
      .e_abs (abs_now)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      clear     = 1'b0;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SWEEP;
               clear     = 1'b1;
            end
         end
         SWEEP: begin
            busy  = 1'b1;
            issue = 1'b1;
            if (cnt == LAST_PAIR) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // done marks the first IDLE cycle, i.e. the cycle after DRAIN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b0;
      end else begin
         done <= (state == DRAIN);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         e_q     <= '0;
         abs_q   <= '0;
         valid_q <= 1'b0;
         err_cnt <= '0;
         sae     <= '0;
         err_sum <= '0;
         max_abs <= '0;
      end else if (clear) begin
         cnt     <= '0;
         e_q     <= '0;
         abs_q   <= '0;
         valid_q <= 1'b0;
         err_cnt <= '0;
         sae     <= '0;
         err_sum <= '0;
         max_abs <= '0;
      end else begin
         valid_q <= issue;
         if (issue) begin
            cnt   <= cnt + (2 * W)'(1);
            e_q   <= e_now;
            abs_q <= abs_now;
         end
         if (valid_q) begin
            err_cnt <= err_cnt + CNT_W'(|e_q);
            sae     <= sae + SAE_W'(abs_q);
            err_sum <= err_sum + {{(SUM_W - W - 2){e_q[W+1]}}, e_q};
            if (max_abs <= abs_q) begin
               max_abs <= abs_q;
            end
         end
      end
   end

endmodule
